// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up at the end.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_start,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_flush,
    output logic            out_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t            state_r;
    logic [2:0]        funct3_r;
    logic [4:0]        rd_r;
    logic [XLEN-1:0]   a_mag_r;
    logic [XLEN-1:0]   b_mag_r;
    logic              neg_r;
    logic [CW-1:0]     cnt_r;
    logic [2*XLEN-1:0] prod_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   out_result_r;
    logic [4:0]        out_rd_r;

    logic              a_signed_s;
    logic              b_signed_s;
    logic              sign_a_s;
    logic              sign_b_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              neg_s;
    logic              is_div_s;
    logic              special_s;
    logic [XLEN-1:0]   special_res_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   fix_res_s;

    // Operand decode: signedness, magnitudes, result sign and special-case detection.
    always_comb begin
        a_signed_s    = 1'b0;
        b_signed_s    = 1'b0;
        special_res_s = '0;
        case (in_funct3)
            3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sign_a_s = a_signed_s & in_rs1[XLEN-1];
        sign_b_s = b_signed_s & in_rs2[XLEN-1];
        a_mag_s  = sign_a_s ? neg_x(in_rs1) : in_rs1;
        b_mag_s  = sign_b_s ? neg_x(in_rs2) : in_rs2;
        // Remainder takes the dividend's sign; product and quotient take signA^signB.
        if (in_funct3[2] && in_funct3[1]) begin
            neg_s = sign_a_s;
        end else begin
            neg_s = sign_a_s ^ sign_b_s;
        end
        is_div_s = in_funct3[2];
        if (is_div_s && (in_rs2 == '0)) begin
            special_s     = 1'b1;
            special_res_s = in_funct3[1] ? in_rs1 : ALL_ONES;
        end else if (is_div_s && !in_funct3[0] && (in_rs1 == MIN_NEG) && (in_rs2 == ALL_ONES)) begin
            special_s     = 1'b1;
            special_res_s = in_funct3[1] ? '0 : MIN_NEG;
        end else begin
            special_s     = 1'b0;
            special_res_s = '0;
        end
    end

    // One iteration step of each datapath, and the sign-corrected result selection.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
        div_shift_s = {rem_r, quo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_mag_r};
        prod_fix_s  = neg_r ? neg_2x(prod_r) : prod_r;
        case (funct3_r)
            3'b000:                 fix_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_s = neg_r ? neg_x(quo_r) : quo_r;
            3'b110, 3'b111:         fix_res_s = neg_r ? neg_x(rem_r) : rem_r;
            default:                fix_res_s = '0;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            funct3_r     <= 3'd0;
            rd_r         <= 5'd0;
            a_mag_r      <= '0;
            b_mag_r      <= '0;
            neg_r        <= 1'b0;
            cnt_r        <= '0;
            prod_r       <= '0;
            rem_r        <= '0;
            quo_r        <= '0;
            out_valid_r  <= 1'b0;
            out_result_r <= '0;
            out_rd_r     <= 5'd0;
        end else if (in_flush) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_start && special_s) begin
                        out_result_r <= special_res_s;
                        out_rd_r     <= in_rd;
                        out_valid_r  <= 1'b1;
                        state_r      <= DONE;
                    end else if (in_start) begin
                        funct3_r <= in_funct3;
                        rd_r     <= in_rd;
                        a_mag_r  <= a_mag_s;
                        b_mag_r  <= b_mag_s;
                        neg_r    <= neg_s;
                        cnt_r    <= CW'(XLEN-1);
                        prod_r   <= {{XLEN{1'b0}}, b_mag_s};
                        rem_r    <= '0;
                        quo_r    <= a_mag_s;
                        state_r  <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (funct3_r[2]) begin
                        if (!div_diff_s[XLEN]) begin
                            rem_r <= div_diff_s[XLEN-1:0];
                            quo_r <= {quo_r[XLEN-2:0], 1'b1};
                        end else begin
                            rem_r <= div_shift_s[XLEN-1:0];
                            quo_r <= {quo_r[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        prod_r <= {mul_sum_s, prod_r[XLEN-1:1]};
                    end
                    if (cnt_r == '0) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    out_result_r <= fix_res_s;
                    out_rd_r     <= rd_r;
                    out_valid_r  <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out_stall  = ((state_r == IDLE) & in_start & ~in_flush) | (state_r == CALC) | (state_r == FIX);
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_rd     = out_rd_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, results, specials, flush/reset, back-to-back.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        in_start;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        in_flush;
    logic        out_stall;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_start   (in_start),
        .in_funct3  (in_funct3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_flush   (in_flush),
        .out_stall  (out_stall),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one op in cycle 0 and follow it to out_valid; inputs driven 1 after posedge, sampled at negedge.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int stall_cnt;
        bit seen;
        cyc = 0;
        stall_cnt = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        in_start = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
        while (!seen && cyc <= 60) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (out_stall) stall_cnt++;
                @(posedge clk); #1;
                in_start = 1'b0;
                cyc++;
            end
        end
        check({tag, " seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, out_result, exp_res);
        check({tag, " rd"}, {27'd0, out_rd}, {27'd0, rd});
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({tag, " stall in done"}, {31'd0, out_stall}, 32'd0);
        @(posedge clk); #1;
        in_start = 1'b0;
        @(negedge clk);
        check({tag, " valid one cycle"}, {31'd0, out_valid}, 32'd0);
        check({tag, " result held"}, out_result, exp_res);
    endtask

    initial begin
        int vcnt;
        int first_v;
        int second_v;
        reset = 1'b1; in_start = 1'b0; in_funct3 = 3'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
        in_rd = 5'd0; in_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset valid", {31'd0, out_valid}, 32'd0);
        check("reset result", out_result, 32'd0);
        check("reset rd", {27'd0, out_rd}, 32'd0);
        check("reset stall", {31'd0, out_stall}, 32'd0);

        run_op("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 34);
        run_op("MULH",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 34);
        run_op("MULHU",  3'b011, 32'h8000_0000,  32'h8000_0000, 5'd5,  32'h4000_0000, 34);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 34);
        run_op("DIV",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 34);
        run_op("REM",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 34);
        run_op("REMU",   3'b111, 32'd100,        32'd7,         5'd9,  32'd2,         34);
        run_op("DIVU0",  3'b101, 32'd1234,       32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run_op("REM0",   3'b110, 32'd5,          32'd0,         5'd11, 32'd5,         1);
        run_op("DIVOVF", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        run_op("REMOVF", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1);

        // Flush in cycle 10: idle in cycle 11, result keeps the previous value (0 from REMOVF).
        @(posedge clk); #1;
        in_start = 1'b1; in_funct3 = 3'b101; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd14;
        repeat (10) begin @(posedge clk); #1; in_start = 1'b0; end
        in_flush = 1'b1;
        @(posedge clk); #1;
        in_flush = 1'b0;
        @(negedge clk);
        check("flush stall", {31'd0, out_stall}, 32'd0);
        check("flush valid", {31'd0, out_valid}, 32'd0);
        check("flush result", out_result, 32'd0);
        check("flush rd", {27'd0, out_rd}, 32'd13);
        vcnt = 0;
        repeat (40) begin @(negedge clk); if (out_valid) vcnt++; end
        check("flush no valid", 32'(vcnt), 32'd0);

        run_op("MULpre", 3'b000, 32'd6, 32'd9, 5'd15, 32'd54, 34);

        // Reset in cycle 20 of a multiply: outputs return to zero.
        @(posedge clk); #1;
        in_start = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd3; in_rs2 = 32'd3; in_rd = 5'd16;
        repeat (20) begin @(posedge clk); #1; in_start = 1'b0; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst mid valid", {31'd0, out_valid}, 32'd0);
        check("rst mid result", out_result, 32'd0);
        check("rst mid rd", {27'd0, out_rd}, 32'd0);
        check("rst mid stall", {31'd0, out_stall}, 32'd0);

        run_op("DIVU after", 3'b101, 32'd1000, 32'd3, 5'd17, 32'd333, 34);

        // Back-to-back: start held high; completions at cycles 34 and 69 only.
        vcnt = 0; first_v = -1; second_v = -1;
        @(posedge clk); #1;
        in_start = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd11; in_rs2 = 32'd13; in_rd = 5'd18;
        for (int c = 0; c <= 69; c++) begin
            @(negedge clk);
            if (out_valid) begin
                vcnt++;
                if (first_v < 0) first_v = c; else second_v = c;
            end
            @(posedge clk); #1;
        end
        in_start = 1'b0;
        check("b2b count", 32'(vcnt), 32'd2);
        check("b2b first", 32'(first_v), 32'd34);
        check("b2b second", 32'(second_v), 32'd69);
        check("b2b result", out_result, 32'd143);
        @(negedge clk);
        check("b2b idle stall", {31'd0, out_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
